useq_ctrl: RTL
==============

// Module: useq_ctrl
// PURPOSE
//  Parametrised microprogrammed sequencer, the next-generation CPU control unit: holds CAR/IR/PC and
//  sequences an external synchronous control-word ROM. Adds a micro-subroutine stack, a loop counter,
//  a stall input and conditional PC branching. Sits between the instruction-memory data bus and the
//  datapath control inputs.
// PARAMETERS
//  IW        16   instruction width
//  RAW       3    register-address field width (DA/AA/BA); opcode width OPW = IW-3*RAW (<= CAW)
//  CAW       8    control-address width
//  CFW       13   datapath control-field width
//  PCW       9    program-counter width
//  OFFW      8    branch offset / absolute target / loop-count field = ir[OFFW-1:0]
//  LCW       8    loop-counter width (>= OFFW)
//  STK_DEPTH 4    micro-stack entries (power of 2)
//  CAR_RST   188  CAR reset value
//  PC_RST    0    PC reset value
// PORTS
//  clk      in   1            clock, rising edge
//  rst      in   1            synchronous reset, active-high
//  stall    in   1            freeze sequencer
//  din      in   IW           instruction bus
//  psw      in   4            {Z,N,C,V} = bits {3,2,1,0}
//  cword    in   CAW+10+CFW   ROM data for address car
//  car_nxt  out  CAW          next CAR; drives synchronous ROM address
//  car      out  CAW          current control address
//  cw       out  CFW          datapath control field
//  DA/AA/BA out  RAW each     ir[3RAW-1:2RAW] / ir[2RAW-1:RAW] / ir[RAW-1:0]
//  pc       out  PCW          program counter
//  stk_ovf  out  1            sticky push-on-full
//  stk_unf  out  1            sticky pop-on-empty
// BEHAVIOUR
//  cword fields MSB->LSB: NA[CAW], MS[3], NS[2], MC, IL, PI, PL, LC, cw[CFW].
//  cond (MS): 000 0, 001 1, 010 C, 011 V, 100 Z, 101 N, 110 !C, 111 !Z. tgt = MC ? zext(opcode) : NA.
//  car_nxt, combinational, all arithmetic mod 2^CAW:
//   NS=00 jump:   cond ? tgt : car+1
//   NS=01 call:   cond ? tgt : car+1; push car+1 only if cond taken
//   NS=10 return: pop top (ignores MS); empty -> CAR_RST, set stk_unf
//   NS=11 loop:   lcnt!=0 ? NA (lcnt<=lcnt-1) : car+1
//  Push on full: push dropped, jump still taken, stk_ovf set. Flags clear only on rst.
//  IL: ir<=din. LC: lcnt<=zext(ir[OFFW-1:0]), old ir value; LC overrides a same-cycle NS=11 decrement
//   (branch decision uses old lcnt).
//  PC: PI -> pc+1 (priority). Else PL: MS in {000,001} -> pc<=zext(ir[OFFW-1:0]);
//   MS>=010 -> if cond, pc<=pc+sext(ir[OFFW-1:0]), else hold. Wraps mod 2^PCW.
//  car<=car_nxt every non-stall cycle; 1-cycle latency from cword to next CAR.
//  stall=1: car_nxt=car; car, ir, pc, lcnt, stack, flags hold; cw forced 0; DA/AA/BA keep ir.
//  rst (mid-op or not) overrides stall: car=CAR_RST, car_nxt=CAR_RST, pc=PC_RST, ir=0, lcnt=0,
//   sp=0 (empty), flags=0. cw = cword[CFW-1:0] (ROM-driven; not reset).
// CONFIGURATION
//  USEQ_PARITY_EN defined: extra input cpar (1); even parity required over {cword,cpar}.
//   On mismatch in a non-stall cycle: car_nxt=CAR_RST, cw forced 0, IL/PI/PL/LC/stack/lcnt
//   suppressed; sticky output par_err (reset 0) set.
//  Undefined: no cpar/par_err ports, no check.
// TESTING
//  1 rst 2 cycles -> car=188, car_nxt=188, pc=0, flags 0; release -> car 189 on NS=00, MS=000.
//  2 IL, din=16'h1A45, next word MC=1, MS=001 -> car_nxt=8'h0D, DA=1, AA=0, BA=5.
//  3 ir[7:0]=8'hFE, pc=5, Z=1: PL, MS=100 -> pc=3; Z=0 -> pc stays 5.
//  4 Call at car=20 to NA=60, nested 4 deep, 5th call -> stk_ovf=1, jump taken; 4 returns yield
//    car 4-deep stack in reverse; 5th return -> car=188, stk_unf=1.
//  5 LC with ir[7:0]=3, loop word NS=11, NA=self -> body executes 4 times, then falls through.
//  6 stall=1 for 3 cycles mid-loop -> all state holds, cw=0; rst during stall -> reset values.

Source files
------------

// File: rtl/useq_ctrl_if.sv
// rtl/useq_ctrl_if.sv - instruction bus, control ROM and datapath-control bundle for useq_ctrl
// Optional parity signals cpar/par_err exist only when USEQ_PARITY_EN is defined.
interface useq_ctrl_if #(
    parameter int IW  = 16,
    parameter int RAW = 3,
    parameter int CAW = 8,
    parameter int CFW = 13,
    parameter int PCW = 9
);
    logic [IW-1:0]          din;
    logic [3:0]             psw;
    logic [CAW+10+CFW-1:0]  cword;
    logic [CAW-1:0]         car_nxt;
    logic [CAW-1:0]         car;
    logic [CFW-1:0]         cw;
    logic [RAW-1:0]         DA;
    logic [RAW-1:0]         AA;
    logic [RAW-1:0]         BA;
    logic [PCW-1:0]         pc;
    logic                   stk_ovf;
    logic                   stk_unf;
`ifdef USEQ_PARITY_EN
    logic                   cpar;
    logic                   par_err;

    modport master (
        input  din, psw, cword, cpar,
        output car_nxt, car, cw, DA, AA, BA, pc, stk_ovf, stk_unf, par_err
    );
    modport slave (
        output din, psw, cword, cpar,
        input  car_nxt, car, cw, DA, AA, BA, pc, stk_ovf, stk_unf, par_err
    );
`else
    modport master (
        input  din, psw, cword,
        output car_nxt, car, cw, DA, AA, BA, pc, stk_ovf, stk_unf
    );
    modport slave (
        output din, psw, cword,
        input  car_nxt, car, cw, DA, AA, BA, pc, stk_ovf, stk_unf
    );
`endif
endinterface

// File: rtl/useq_ctrl.sv
// rtl/useq_ctrl.sv - microprogrammed sequencer with micro-stack, loop counter, stall and PC branching
// Optional control-word parity check enabled by defining USEQ_PARITY_EN.
module useq_ctrl #(
    parameter int IW        = 16,
    parameter int RAW       = 3,
    parameter int CAW       = 8,
    parameter int CFW       = 13,
    parameter int PCW       = 9,
    parameter int OFFW      = 8,
    parameter int LCW       = 8,
    parameter int STK_DEPTH = 4,
    parameter int CAR_RST   = 188,
    parameter int PC_RST    = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    useq_ctrl_if.master   bus
);
    localparam int OPW = IW - 3*RAW;
    localparam int SPW = $clog2(STK_DEPTH) + 1;
    localparam logic [CAW-1:0] CAR_INIT = CAW'(CAR_RST);
    localparam logic [PCW-1:0] PC_INIT  = PCW'(PC_RST);

    logic [CAW-1:0] na;
    logic [2:0]     ms;
    logic [1:0]     ns;
    logic           mc, il, pi, pl, lc;
    logic [CFW-1:0] cwf;

    assign {na, ms, ns, mc, il, pi, pl, lc, cwf} = bus.cword;

    logic [CAW-1:0] car_q;
    logic [IW-1:0]  ir_q;
    logic [PCW-1:0] pc_q;
    logic [LCW-1:0] lcnt_q;
    logic [SPW-1:0] sp_q;
    logic           ovf_q, unf_q;
    logic [CAW-1:0] stk [STK_DEPTH];

    logic           par_bad;
`ifdef USEQ_PARITY_EN
    logic           par_err_q;

    // Even parity over {cword,cpar}; a bad word is ignored while frozen
    assign par_bad     = !stall && (^{bus.cword, bus.cpar});
    assign bus.par_err = par_err_q;

    always_ff @(posedge clk) begin
        if (rst)
            par_err_q <= 1'b0;
        else if (par_bad)
            par_err_q <= 1'b1;
    end
`else
    assign par_bad = 1'b0;
`endif

    logic [OPW-1:0] opcode;
    logic [CAW-1:0] car_inc, tgt, stk_top, car_nxt_c;
    logic [SPW-1:0] sp_dec;
    logic           cond, sp_full, sp_empty;
    logic           push, pop, ovf_set, unf_set, lcnt_dec;
    logic [PCW-1:0] pc_nxt;

    assign opcode   = ir_q[IW-1:3*RAW];
    assign car_inc  = car_q + CAW'(1);
    assign tgt      = mc ? CAW'(opcode) : na;
    assign sp_full  = (sp_q == SPW'(STK_DEPTH));
    assign sp_empty = (sp_q == '0);
    assign sp_dec   = sp_q - SPW'(1);
    assign stk_top  = stk[sp_dec[SPW-2:0]];

    always_comb begin
        cond = 1'b0;
        case (ms)
            3'b000: cond = 1'b0;
            3'b001: cond = 1'b1;
            3'b010: cond = bus.psw[1];
            3'b011: cond = bus.psw[0];
            3'b100: cond = bus.psw[3];
            3'b101: cond = bus.psw[2];
            3'b110: cond = !bus.psw[1];
            default: cond = !bus.psw[3];
        endcase
    end

    // Next control address; reset and stall win over the microword
    always_comb begin
        car_nxt_c = car_q;
        push      = 1'b0;
        pop       = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        lcnt_dec  = 1'b0;
        if (rst) begin
            car_nxt_c = CAR_INIT;
        end else if (stall) begin
            car_nxt_c = car_q;
        end else if (par_bad) begin
            car_nxt_c = CAR_INIT;
        end else begin
            case (ns)
                2'b00: car_nxt_c = cond ? tgt : car_inc;
                2'b01: begin
                    car_nxt_c = cond ? tgt : car_inc;
                    if (cond) begin
                        if (sp_full) ovf_set = 1'b1;
                        else         push    = 1'b1;
                    end
                end
                2'b10: begin
                    if (sp_empty) begin
                        car_nxt_c = CAR_INIT;
                        unf_set   = 1'b1;
                    end else begin
                        car_nxt_c = stk_top;
                        pop       = 1'b1;
                    end
                end
                default: begin
                    if (lcnt_q != '0) begin
                        car_nxt_c = na;
                        lcnt_dec  = 1'b1;
                    end else begin
                        car_nxt_c = car_inc;
                    end
                end
            endcase
        end
    end

    always_comb begin
        pc_nxt = pc_q;
        if (pi)
            pc_nxt = pc_q + PCW'(1);
        else if (pl) begin
            if (ms[2:1] == 2'b00)
                pc_nxt = PCW'(ir_q[OFFW-1:0]);
            else if (cond)
                pc_nxt = pc_q + PCW'($signed(ir_q[OFFW-1:0]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            car_q  <= CAR_INIT;
            ir_q   <= '0;
            pc_q   <= PC_INIT;
            lcnt_q <= '0;
            sp_q   <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else if (!stall) begin
            car_q <= car_nxt_c;
            if (!par_bad) begin
                if (il)
                    ir_q <= bus.din;
                pc_q <= pc_nxt;
                // A fresh load beats a same-cycle loop decrement
                if (lc)
                    lcnt_q <= LCW'(ir_q[OFFW-1:0]);
                else if (lcnt_dec)
                    lcnt_q <= lcnt_q - LCW'(1);
                if (push)
                    sp_q <= sp_q + SPW'(1);
                else if (pop)
                    sp_q <= sp_dec;
                if (ovf_set)
                    ovf_q <= 1'b1;
                if (unf_set)
                    unf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            stk[sp_q[SPW-2:0]] <= car_inc;
    end

    assign bus.car_nxt = car_nxt_c;
    assign bus.car     = car_q;
    assign bus.cw      = (!rst && (stall || par_bad)) ? '0 : cwf;
    assign bus.DA      = ir_q[3*RAW-1:2*RAW];
    assign bus.AA      = ir_q[2*RAW-1:RAW];
    assign bus.BA      = ir_q[RAW-1:0];
    assign bus.pc      = pc_q;
    assign bus.stk_ovf = ovf_q;
    assign bus.stk_unf = unf_q;
endmodule
